// File: rtl/panel_write_arbiter.sv
// panel_write_arbiter: two per-port FIFOs sharing the LED-panel write port,
// round-robin granted (optional lock to A) with a programmable post-write gap.
module panel_write_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int WR_GAP = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [5:0]  a_en,
   input  logic [15:0] a_addr,
   input  logic [23:0] a_wdat,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [5:0]  b_en,
   input  logic [15:0] b_addr,
   input  logic [23:0] b_wdat,
   input  logic        lock_a,
   output logic [5:0]  ctrl_en,
   output logic [3:0]  ctrl_wr,
   output logic [15:0] ctrl_addr,
   output logic [23:0] ctrl_wdat,
   output logic        busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int GW = WR_GAP > 0 ? $clog2(WR_GAP + 1) : 1;
   logic [45:0] a_mem [FIFO_DEPTH];
   logic [45:0] b_mem [FIFO_DEPTH];
   logic [AW-1:0] a_wp, a_rp, b_wp, b_rp;
   logic [CW-1:0] a_count, b_count;
   logic [GW-1:0] gap_cnt;
   logic last_b, a_push, b_push, a_pop, b_pop, a_ne, b_ok, go, grant_b;
   logic [45:0] head;
   logic [5:0] en_q;
   logic [15:0] addr_q;
   logic [23:0] wdat_q;
   always_comb begin
      a_ready = !reset && a_count != CW'(FIFO_DEPTH);
      b_ready = !reset && b_count != CW'(FIFO_DEPTH);
      a_push = a_valid && a_ready;
      b_push = b_valid && b_ready;
      a_ne = a_count != '0;
      b_ok = b_count != '0 && !lock_a;
      go = gap_cnt == '0 && (a_ne || b_ok);
      // last_b set means A is owed the next contested grant
      grant_b = b_ok && (!a_ne || !last_b);
      a_pop = go && !grant_b;
      b_pop = go && grant_b;
      head = grant_b ? b_mem[b_rp] : a_mem[a_rp];
      busy = !reset && (a_ne || b_count != '0 || gap_cnt != '0);
      ctrl_en = reset ? '0 : en_q;
      ctrl_addr = reset ? '0 : addr_q;
      ctrl_wdat = reset ? '0 : wdat_q;
   end
   assign ctrl_wr = 4'b0111;
   always_ff @(posedge clock) begin
      if (a_push) a_mem[a_wp] <= {a_en, a_addr, a_wdat};
      if (b_push) b_mem[b_wp] <= {b_en, b_addr, b_wdat};
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         a_wp <= '0;
         a_rp <= '0;
         b_wp <= '0;
         b_rp <= '0;
         a_count <= '0;
         b_count <= '0;
         gap_cnt <= '0;
         last_b <= 1'b1;
         en_q <= '0;
         addr_q <= '0;
         wdat_q <= '0;
      end else begin
         a_wp <= a_wp + AW'(a_push);
         a_rp <= a_rp + AW'(a_pop);
         b_wp <= b_wp + AW'(b_push);
         b_rp <= b_rp + AW'(b_pop);
         a_count <= a_count + CW'(a_push) - CW'(a_pop);
         b_count <= b_count + CW'(b_push) - CW'(b_pop);
         if (go) begin
            en_q <= head[45:40];
            addr_q <= head[39:24];
            wdat_q <= head[23:0];
            // zero-mask entries consume a grant but leave the gap unloaded
            gap_cnt <= head[45:40] != '0 ? GW'(WR_GAP) : '0;
            last_b <= grant_b;
         end else begin
            en_q <= '0;
            if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
         end
      end
   end
endmodule

// File: tb/tb_panel_write_arbiter.sv
// tb_panel_write_arbiter: directed scenarios plus random traffic on two instances
// (WR_GAP=0 and WR_GAP=3), continuously compared against a queue-based model.
module tb_panel_write_arbiter;
   localparam int D = 4;
   logic clock = 0, reset = 1, a_valid = 0, b_valid = 0, lock_a = 0;
   logic [5:0] a_en = 0, b_en = 0;
   logic [15:0] a_addr = 0, b_addr = 0;
   logic [23:0] a_wdat = 0, b_wdat = 0;
   logic a_ready [2], b_ready [2], busy [2];
   logic [5:0] c_en [2];
   logic [3:0] c_wr [2];
   logic [15:0] c_addr [2];
   logic [23:0] c_wdat [2];
   int checks = 0, failures = 0;
   always #5 clock = ~clock;
   panel_write_arbiter #(.FIFO_DEPTH(D), .WR_GAP(0)) u0 (
      .clock(clock), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready[0]), .a_en(a_en), .a_addr(a_addr), .a_wdat(a_wdat),
      .b_valid(b_valid), .b_ready(b_ready[0]), .b_en(b_en), .b_addr(b_addr), .b_wdat(b_wdat),
      .lock_a(lock_a), .ctrl_en(c_en[0]), .ctrl_wr(c_wr[0]), .ctrl_addr(c_addr[0]),
      .ctrl_wdat(c_wdat[0]), .busy(busy[0]));
   panel_write_arbiter #(.FIFO_DEPTH(D), .WR_GAP(3)) u1 (
      .clock(clock), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready[1]), .a_en(a_en), .a_addr(a_addr), .a_wdat(a_wdat),
      .b_valid(b_valid), .b_ready(b_ready[1]), .b_en(b_en), .b_addr(b_addr), .b_wdat(b_wdat),
      .lock_a(lock_a), .ctrl_en(c_en[1]), .ctrl_wr(c_wr[1]), .ctrl_addr(c_addr[1]),
      .ctrl_wdat(c_wdat[1]), .busy(busy[1]));
   // reference model: one pair of queues per instance, decisions from pre-edge state
   logic [45:0] qa [2][$];
   logic [45:0] qb [2][$];
   int mg [2];
   int gapv [2] = '{0, 3};
   bit mlb [2];
   logic [5:0] me [2];
   logic [15:0] ma [2];
   logic [23:0] mw [2];
   int sa, sb;
   bit pa, pb, ha, hb, take_b;
   logic [45:0] h;
   initial forever begin
      @(posedge clock);
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            qa[i].delete();
            qb[i].delete();
            mg[i] = 0;
            mlb[i] = 1;
            me[i] = 0;
            ma[i] = 0;
            mw[i] = 0;
         end else begin
            sa = qa[i].size();
            sb = qb[i].size();
            pa = a_valid && sa != D;
            pb = b_valid && sb != D;
            ha = sa > 0;
            hb = sb > 0 && !lock_a;
            if (mg[i] == 0 && (ha || hb)) begin
               take_b = (ha && hb) ? !mlb[i] : hb;
               h = take_b ? qb[i].pop_front() : qa[i].pop_front();
               me[i] = h[45:40];
               ma[i] = h[39:24];
               mw[i] = h[23:0];
               mg[i] = h[45:40] != 0 ? gapv[i] : 0;
               mlb[i] = take_b;
            end else begin
               me[i] = 0;
               if (mg[i] > 0) mg[i]--;
            end
            if (pa) qa[i].push_back({a_en, a_addr, a_wdat});
            if (pb) qb[i].push_back({b_en, b_addr, b_wdat});
         end
      end
   end
   initial forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         checks += 6;
         if (c_en[i] !== (reset ? 6'h0 : me[i])) begin
            failures++;
            $display("FAIL mon_en[%0d] t=%0t got=%h exp=%h", i, $time, c_en[i], reset ? 6'h0 : me[i]);
         end
         if (c_addr[i] !== (reset ? 16'h0 : ma[i]) || c_wdat[i] !== (reset ? 24'h0 : mw[i])) begin
            failures++;
            $display("FAIL mon_data[%0d] t=%0t got=%h/%h exp=%h/%h", i, $time, c_addr[i], c_wdat[i], ma[i], mw[i]);
         end
         if (a_ready[i] !== (!reset && qa[i].size() != D)) begin
            failures++;
            $display("FAIL mon_a_ready[%0d] t=%0t got=%b", i, $time, a_ready[i]);
         end
         if (b_ready[i] !== (!reset && qb[i].size() != D)) begin
            failures++;
            $display("FAIL mon_b_ready[%0d] t=%0t got=%b", i, $time, b_ready[i]);
         end
         if (busy[i] !== (!reset && (qa[i].size() != 0 || qb[i].size() != 0 || mg[i] != 0))) begin
            failures++;
            $display("FAIL mon_busy[%0d] t=%0t got=%b", i, $time, busy[i]);
         end
         if (c_wr[i] !== 4'b0111) begin
            failures++;
            $display("FAIL mon_wr[%0d] t=%0t got=%h exp=7", i, $time, c_wr[i]);
         end
      end
   end
   task automatic tick;
      @(posedge clock);
      #1;
   endtask
   task automatic do_reset;
      tick;
      reset = 1;
      a_valid = 0;
      b_valid = 0;
      lock_a = 0;
      tick;
      tick;
      reset = 0;
   endtask
   task automatic test_reset;
      tick;
      reset = 1;
      a_valid = 1;
      @(negedge clock);
      checks++;
      if (c_en[0] !== 0 || busy[0] !== 0 || a_ready[0] !== 0 || b_ready[0] !== 0 || c_addr[0] !== 0 || c_wr[0] !== 4'b0111) begin
         failures++;
         $display("FAIL reset_outputs en=%h busy=%b ar=%b br=%b addr=%h wr=%h exp 0/0/0/0/0/7",
                  c_en[0], busy[0], a_ready[0], b_ready[0], c_addr[0], c_wr[0]);
      end
      a_valid = 0;
      tick;
      reset = 0;
   endtask
   task automatic test_single;
      do_reset;
      a_valid = 1;
      a_en = 6'h01;
      a_addr = 16'h0010;
      a_wdat = 24'h112233;
      tick;
      a_valid = 0;
      @(negedge clock);
      checks++;
      if (c_en[0] !== 6'h00 || busy[0] !== 1) begin
         failures++;
         $display("FAIL single_wait en=%h busy=%b exp 00/1", c_en[0], busy[0]);
      end
      tick;
      @(negedge clock);
      checks++;
      if (c_en[0] !== 6'h01 || c_addr[0] !== 16'h0010 || c_wdat[0] !== 24'h112233 || busy[0] !== 0) begin
         failures++;
         $display("FAIL single_pulse en=%h addr=%h wdat=%h busy=%b exp 01/0010/112233/0", c_en[0], c_addr[0], c_wdat[0], busy[0]);
      end
      tick;
      @(negedge clock);
      checks++;
      if (c_en[0] !== 6'h00) begin
         failures++;
         $display("FAIL single_after en=%h exp 00", c_en[0]);
      end
   endtask
   task automatic test_back_to_back;
      logic [15:0] ea;
      do_reset;
      for (int e = 1; e <= 7; e++) begin
         a_valid = e <= 3;
         b_valid = e <= 3;
         a_en = 6'h02;
         b_en = 6'h04;
         a_addr = 16'hA000 + 16'(e - 1);
         b_addr = 16'hB000 + 16'(e - 1);
         a_wdat = 24'($urandom);
         b_wdat = 24'($urandom);
         tick;
         @(negedge clock);
         if (e >= 2) begin
            ea = ((e % 2) == 1 ? 16'hB000 : 16'hA000) + 16'((e - 2) / 2);
            checks++;
            if (c_en[0] !== ((e % 2) == 1 ? 6'h04 : 6'h02) || c_addr[0] !== ea) begin
               failures++;
               $display("FAIL b2b_order[%0d] en=%h addr=%h exp addr %h", e - 2, c_en[0], c_addr[0], ea);
            end
         end
      end
      b_valid = 0;
      a_valid = 0;
   endtask
   task automatic test_backpressure;
      do_reset;
      lock_a = 1;
      for (int c = 0; c < 6; c++) begin
         a_valid = c < 4;
         a_en = 6'h10;
         a_addr = 16'hC000 + 16'(c);
         b_valid = 1;
         b_en = 6'h08;
         b_addr = 16'hB100 + 16'(c);
         @(negedge clock);
         checks++;
         if (b_ready[0] !== (c < 4) || c_en[0] === 6'h08) begin
            failures++;
            $display("FAIL bp_fill[%0d] b_ready=%b en=%h exp ready %0d, no B", c, b_ready[0], c_en[0], c < 4);
         end
         tick;
      end
      a_valid = 0;
      b_valid = 0;
      for (int c = 0; c < 6; c++) begin
         tick;
         @(negedge clock);
         checks++;
         if (c_en[0] === 6'h08 || b_ready[0] !== 0) begin
            failures++;
            $display("FAIL bp_locked[%0d] en=%h b_ready=%b exp no B, ready 0", c, c_en[0], b_ready[0]);
         end
      end
      lock_a = 0;
      for (int k = 0; k < 4; k++) begin
         tick;
         @(negedge clock);
         checks++;
         if (c_en[0] !== 6'h08 || c_addr[0] !== 16'hB100 + 16'(k)) begin
            failures++;
            $display("FAIL bp_drain[%0d] en=%h addr=%h exp 08/%h", k, c_en[0], c_addr[0], 16'hB100 + 16'(k));
         end
      end
      checks++;
      if (b_ready[0] !== 1) begin
         failures++;
         $display("FAIL bp_ready_back b_ready=%b exp 1", b_ready[0]);
      end
   endtask
   task automatic test_gap;
      do_reset;
      for (int n = 1; n <= 12; n++) begin
         a_valid = n <= 2;
         a_en = 6'h01;
         a_addr = 16'hD000 + 16'(n);
         tick;
         @(negedge clock);
         checks++;
         if (c_en[1] !== ((n == 2 || n == 6) ? 6'h01 : 6'h00) || busy[1] !== (n <= 8)) begin
            failures++;
            $display("FAIL gap_cycle[%0d] en=%h busy=%b exp %h/%0d", n, c_en[1], busy[1],
                     (n == 2 || n == 6) ? 6'h01 : 6'h00, n <= 8);
         end
      end
      a_valid = 0;
   endtask
   task automatic test_zero_mask;
      do_reset;
      for (int n = 1; n <= 4; n++) begin
         a_valid = n <= 2;
         a_en = n == 1 ? 6'h00 : 6'h3F;
         a_addr = 16'h0200 + 16'(n - 1);
         tick;
         @(negedge clock);
         if (n == 2) begin
            checks++;
            if (c_en[1] !== 6'h00 || c_addr[1] !== 16'h0200 || c_en[0] !== 6'h00) begin
               failures++;
               $display("FAIL zero_pop en1=%h addr1=%h en0=%h exp 00/0200/00", c_en[1], c_addr[1], c_en[0]);
            end
         end
         if (n == 3) begin
            checks++;
            if (c_en[1] !== 6'h3F || c_addr[1] !== 16'h0201 || c_en[0] !== 6'h3F) begin
               failures++;
               $display("FAIL zero_next en1=%h addr1=%h en0=%h exp 3f/0201/3f", c_en[1], c_addr[1], c_en[0]);
            end
         end
      end
      a_valid = 0;
   endtask
   task automatic test_reset_mid;
      do_reset;
      lock_a = 1;
      for (int n = 0; n < 3; n++) begin
         a_valid = 1;
         b_valid = n < 2;
         a_en = 6'h20;
         b_en = 6'h20;
         tick;
      end
      a_valid = 0;
      b_valid = 0;
      reset = 1;
      tick;
      tick;
      reset = 0;
      lock_a = 0;
      @(negedge clock);
      checks++;
      if (a_ready[1] !== 1 || b_ready[1] !== 1 || busy[1] !== 0) begin
         failures++;
         $display("FAIL mid_release ar=%b br=%b busy=%b exp 1/1/0", a_ready[1], b_ready[1], busy[1]);
      end
      for (int n = 0; n < 4; n++) begin
         tick;
         @(negedge clock);
         checks++;
         if (c_en[0] !== 0 || c_en[1] !== 0) begin
            failures++;
            $display("FAIL mid_quiet[%0d] en0=%h en1=%h exp 00", n, c_en[0], c_en[1]);
         end
      end
      a_valid = 1;
      a_en = 6'h01;
      a_addr = 16'hE000;
      tick;
      a_valid = 0;
      tick;
      @(negedge clock);
      checks++;
      if (c_en[1] !== 6'h01 || c_addr[1] !== 16'hE000) begin
         failures++;
         $display("FAIL mid_new en=%h addr=%h exp 01/e000", c_en[1], c_addr[1]);
      end
   endtask
   task automatic test_random;
      int n;
      do_reset;
      for (int c = 0; c < 600; c++) begin
         reset = $urandom_range(0, 149) == 0;
         lock_a = $urandom_range(0, 9) < 3;
         a_valid = $urandom_range(0, 1) == 1;
         b_valid = $urandom_range(0, 2) != 0;
         a_en = $urandom_range(0, 7) == 0 ? 6'h00 : 6'($urandom);
         b_en = $urandom_range(0, 7) == 0 ? 6'h00 : 6'($urandom);
         a_addr = 16'($urandom);
         b_addr = 16'($urandom);
         a_wdat = 24'($urandom);
         b_wdat = 24'($urandom);
         tick;
      end
      reset = 0;
      lock_a = 0;
      a_valid = 0;
      b_valid = 0;
      n = 0;
      while ((busy[0] || busy[1]) && n < 100) begin
         tick;
         n++;
      end
      @(negedge clock);
      checks++;
      if (busy[0] !== 0 || busy[1] !== 0) begin
         failures++;
         $display("FAIL random_drain busy=%b/%b after %0d cycles exp 0/0", busy[0], busy[1], n);
      end
   endtask
   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_backpressure;
      test_gap;
      test_zero_mask;
      test_reset_mid;
      test_random;
      tick;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
